// File: rtl/softmax_sequencer.sv
// Streaming argmax over one frame of LAYER_SZ signed neuron outputs.
// Tracks the running maximum per accepted beat and holds the winning index/score until accepted.
module softmax_sequencer #(
    parameter int SIZE     = 16,
    parameter int LAYER_SZ = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [SIZE-1:0] in_data,
    input  logic            in_last,
    output logic            in_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] class_out,
    output logic [SIZE-1:0] max_out,
    output logic            frame_err
);

    localparam logic [SIZE-1:0] LAST_IDX = SIZE'(LAYER_SZ - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        RESULT  = 1'b1
    } state_t;

    state_t          state;
    logic [SIZE-1:0] cnt;
    logic [SIZE-1:0] max_reg;
    logic [SIZE-1:0] class_reg;
    logic            err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= COLLECT;
            cnt       <= '0;
            max_reg   <= '0;
            class_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (in_valid) begin
                        if (cnt == '0) begin
                            max_reg   <= in_data;
                            class_reg <= '0;
                            err_reg   <= 1'b0;
                        end else if ($signed(in_data) > $signed(max_reg)) begin
                            max_reg   <= in_data;
                            class_reg <= cnt;
                        end
                        // A frame closes on in_last or on the final beat; error when exactly one of them holds.
                        if (in_last || (cnt == LAST_IDX)) begin
                            state   <= RESULT;
                            cnt     <= '0;
                            err_reg <= in_last != (cnt == LAST_IDX);
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                RESULT: begin
                    if (out_ready) begin
                        state <= COLLECT;
                        cnt   <= '0;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

    assign in_ready  = (state == COLLECT);
    assign out_valid = (state == RESULT);
    assign class_out = class_reg;
    assign max_out   = max_reg;
    assign frame_err = err_reg;

endmodule

// File: tb/tb_softmax_sequencer.sv
// Self-checking bench for softmax_sequencer: directed test-plan frames plus randomized frames
// checked against a frame-level argmax model.
module tb_softmax_sequencer;

    localparam int N = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_last;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] class_out;
    logic [15:0] max_out;
    logic        frame_err;

    int checks = 0;
    int errors = 0;

    logic [15:0] beats [N];

    softmax_sequencer #(.SIZE(16), .LAYER_SZ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .class_out (class_out),
        .max_out   (max_out),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running, want finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive n beats from beats[]; in_last on the final one when use_last.
    task automatic feed(input int n, input bit use_last, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    in_valid  = 1'b0;
                    in_data   = 16'($urandom);
                    in_last   = 1'($urandom);
                    out_ready = 1'($urandom);
                    tick();
                    check("gap_ready", in_ready, 1);
                    check("gap_no_valid", out_valid, 0);
                end
            end
            in_valid  = 1'b1;
            in_data   = beats[i];
            in_last   = use_last && (i == n - 1);
            out_ready = (i == n - 1) ? 1'b0 : 1'($urandom);
            tick();
            if (i < n - 1) check("no_early_valid", out_valid, 0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Check the result of a frame of n beats, hold it for `hold` cycles, then hand it off.
    task automatic check_result(input int n, input bit use_last, input int hold);
        int          exp_cls;
        logic [15:0] exp_max;
        bit          exp_err;
        exp_cls = 0;
        exp_max = beats[0];
        for (int i = 1; i < n; i++) begin
            if ($signed(beats[i]) > $signed(exp_max)) begin
                exp_max = beats[i];
                exp_cls = i;
            end
        end
        exp_err = (use_last && n < N) || (!use_last && n == N);

        check("res_valid", out_valid, 1);
        check("res_ready", in_ready, 0);
        check("res_class", class_out, exp_cls);
        check("res_max", max_out, exp_max);
        check("res_err", frame_err, exp_err);

        for (int h = 0; h < hold; h++) begin
            in_valid  = 1'($urandom);
            in_data   = 16'($urandom);
            in_last   = 1'($urandom);
            out_ready = 1'b0;
            tick();
            check("hold_valid", out_valid, 1);
            check("hold_ready", in_ready, 0);
            check("hold_class", class_out, exp_cls);
            check("hold_max", max_out, exp_max);
            check("hold_err", frame_err, exp_err);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("handoff_valid", out_valid, 0);
        check("handoff_ready", in_ready, 1);
    endtask

    task automatic frame(input int n, input bit use_last, input int hold, input bit gaps);
        feed(n, use_last, gaps);
        check_result(n, use_last, hold);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_class"}, class_out, 0);
        check({tag, "_max"}, max_out, 0);
        check({tag, "_err"}, frame_err, 0);
    endtask

    task automatic fill_random_below(input logic [15:0] limit);
        for (int i = 0; i < N; i++) beats[i] = 16'($urandom_range(0, int'(limit) - 1));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check_reset_state("reset");
        rst = 1'b0;

        // Basic frame
        beats = '{16'h0800, 16'h0900, 16'h0700, 16'h0400, 16'h0200,
                  16'h0300, 16'h0500, 16'h0000, 16'h0700, 16'h0800};
        feed(N, 1'b1, 1'b0);
        check("basic_class", class_out, 1);
        check("basic_max", max_out, 16'h0900);
        check_result(N, 1'b1, 0);

        // Max at index 0, then index 2
        fill_random_below(16'h7F00);
        beats[0] = 16'h7F00;
        frame(N, 1'b1, 0, 1'b0);
        fill_random_below(16'h7F00);
        beats[2] = 16'h7F00;
        frame(N, 1'b1, 0, 1'b0);

        // Ties keep the lowest index; negatives compare signed
        for (int i = 0; i < N; i++) beats[i] = 16'h0500;
        frame(N, 1'b1, 0, 1'b0);
        for (int i = 0; i < N; i++) beats[i] = 16'h8000;
        beats[6] = 16'hFF00;
        feed(N, 1'b1, 1'b0);
        check("neg_class", class_out, 6);
        check("neg_max", max_out, 16'hFF00);
        check_result(N, 1'b1, 0);

        // Backpressure, then a frame peaking at index 9
        fill_random_below(16'h4000);
        frame(N, 1'b1, 5, 1'b0);
        for (int i = 0; i < N; i++) beats[i] = 16'(i * 256);
        frame(N, 1'b1, 0, 1'b0);

        // Short frame and missing in_last
        beats[0] = 16'h0100; beats[1] = 16'h0400; beats[2] = 16'h0200; beats[3] = 16'h0300;
        feed(4, 1'b1, 1'b0);
        check("short_class", class_out, 1);
        check("short_err", frame_err, 1);
        check_result(4, 1'b1, 0);
        fill_random_below(16'hFFFF);
        frame(N, 1'b0, 0, 1'b0);

        // Reset mid-frame
        fill_random_below(16'hFFFF);
        feed(6, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state("rst_mid");
        fill_random_below(16'h8000);
        beats[7] = 16'h7FFF;
        frame(N, 1'b1, 0, 1'b0);

        // Reset while a result is pending
        fill_random_below(16'hFFFF);
        feed(N, 1'b1, 1'b0);
        check("pend_valid", out_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state("rst_result");
        fill_random_below(16'hFFFF);
        frame(N, 1'b1, 0, 1'b0);

        // Randomized frames
        for (int f = 0; f < 60; f++) begin
            int n;
            bit use_last;
            for (int i = 0; i < N; i++) beats[i] = 16'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                n = N;
                use_last = 1'b0;
            end else begin
                n = $urandom_range(1, N);
                use_last = 1'b1;
            end
            if ($urandom_range(0, 4) == 0) begin
                for (int i = 0; i < N; i++) beats[i] = 16'($urandom_range(0, 3));
            end
            frame(n, use_last, $urandom_range(0, 3), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/softmax_sequencer.md
# softmax_sequencer

Streaming argmax (softmax classification) controller for the fully-connected output layer. Accepts the LAYER_SZ signed fixed-point neuron outputs of one frame one per cycle over a valid/ready handshake and tracks the running maximum with a per-beat compare. Once the frame closes, it presents the winning class index and its score on a held output handshake. It replaces the all-at-once combinational compare tree when the final layer emits neurons serially.

## Interface
- SIZE, 16: data width; signed 8.8 fixed point; also the width of class_out.
- LAYER_SZ, 10: neurons per frame; legal range 2..2^SIZE.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data/in_last are valid this cycle.
- in_data  in  SIZE  signed neuron value.
- in_last  in  1  marks the final beat of the frame.
- in_ready  out  1  block can accept a beat.
- out_valid  out  1  result is valid; held until accepted.
- out_ready  in  1  consumer accepts the result.
- class_out  out  SIZE  index of the maximum value, zero-extended.
- max_out  out  SIZE  the maximum value itself.
- frame_err  out  1  the frame was framed incorrectly by in_last; qualified by out_valid.

## Operation
- FSM states:
  - COLLECT (reset state): in_ready=1, out_valid=0.
  - RESULT: in_ready=0, out_valid=1.
- Beat counter cnt runs 0..LAYER_SZ-1 and is cleared on entry to COLLECT.
- A beat is accepted when in_valid && in_ready.
  - With cnt==0: max_reg=in_data, class_reg=0, err_reg=0.
  - With cnt>0: if in_data > max_reg (signed, strict), max_reg=in_data and class_reg=cnt; otherwise both hold.
  - Ties keep the lower index.
- Frame close: an accepted beat closes the frame if in_last=1 or cnt==LAYER_SZ-1. The FSM then moves to RESULT.
- frame_err on close:
  - Set if in_last=1 and cnt<LAYER_SZ-1 (short frame). class_out/max_out reflect only the beats received.
  - Set if cnt==LAYER_SZ-1 and in_last=0 (missing last). The next beat starts a new frame.
  - Cleared in all other cases.
- RESULT: class_out, max_out and frame_err stay stable while out_valid=1 && out_ready=0. When out_valid && out_ready, the FSM returns to COLLECT and cnt=0.
- in_valid during RESULT is ignored: in_ready=0 and no state changes.
- out_ready during COLLECT is ignored.
- Comparison is a full SIZE-bit signed compare. There is no saturation and no arithmetic beyond the compare.

## Timing
- Reset, sampled at the clk edge while rst=1:
  - State and counters: state=COLLECT, cnt=0.
  - Outputs: in_ready=1, out_valid=0, class_out=0, max_out=0, frame_err=0.
- Reset mid-frame or mid-RESULT discards the partial frame or the pending result. The first accepted beat after rst falls is index 0.
- in_ready and out_valid are registered-state decodes with no combinational path from in_valid or out_ready.
- Latency: out_valid rises on the cycle after the closing beat is accepted.
- Minimum frame period is LAYER_SZ+1 cycles: LAYER_SZ beats plus one RESULT cycle with out_ready=1.
- Back-to-back frames: the cycle after the out handshake, in_ready=1 and beat 0 of the next frame may be accepted.
- in_valid gaps in COLLECT stall cnt with no timeout.

## Test plan
- **Basic frame:** beats 0x0800,0x0900,0x0700,0x0400,0x0200,0x0300,0x0500,0x0000,0x0700,0x0800 with in_last on beat 9 and out_ready=1.
  - Cycle after beat 9: out_valid=1, class_out=1, max_out=0x0900, frame_err=0.
  - Next cycle: out_valid=0 and in_ready=1.
- **Max at index 0 / index 2:** with beat0=0x7F00, expect class 0. With beat2=0x7F00, expect class 2, max_out=0x7F00.
- **Ties and negatives:**
  - All beats 0x0500: expect class 0.
  - Beats all 0x8000 except beat6=0xFF00: expect class 6, max_out=0xFF00 (signed compare).
- **Backpressure:** out_ready=0 for 5 cycles after a result.
  - Outputs stay stable and in_ready=0.
  - in_valid pulses during RESULT are dropped.
  - After out_ready=1, the next frame (max at index 9) yields class 9.
- **Framing errors:**
  - in_last on beat 3 of values 1,4,2,3 (<<8): out_valid after beat 3, class_out=1, frame_err=1.
  - 10 beats without in_last: result issued after beat 9 with frame_err=1.
- **Reset mid-operation:**
  - rst for 1 cycle after beat 5 of a frame: outputs return to reset values, and a fresh 10-beat frame gives its correct class.
  - rst during RESULT with out_ready=0: out_valid=0 on the next cycle.
